// File: rtl/uart_transceiver_pkg.sv
// ============================================================================
// Module      : UartGlobalPkg
// Description : Shared definitions for the UART transceiver. It holds the
//               FSM state encoding used by both TX and RX, the legal
//               parameter ranges, and the parity-bit count selected by the
//               compile-time parity option.
// Options     : UART_PARITY_EN -- when defined, a parity bit is included in
//               every frame.
// Revision    : 1.0 -- initial release
// ============================================================================
`default_nettype none

package UartGlobalPkg;

    // Frame-level state. TX and RX both use this encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Legal parameter ranges. These are checked when the design elaborates.
    localparam int DATA_WIDTH_MIN   = 5;
    localparam int DATA_WIDTH_MAX   = 9;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;
    localparam int CLKS_PER_BIT_MIN = 4;

    // Bit counter width. It covers data indices 0..DATA_WIDTH_MAX-1.
    localparam int BIT_CNT_W = 4;

`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage : UartGlobalPkg

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module      : uart_rx_sampler
// Description : UART receive path. The asynchronous rx pin passes through a
//               2-flop synchronizer. One history flop then provides
//               falling-edge detection. After a start edge the FSM waits
//               half a bit period to validate the start bit. It then samples
//               every later bit at mid-bit and registers the completed word
//               together with its error flags.
// Ports       : clk, reset (async, active-low), rx (serial in),
//               rx_data / rx_valid / rx_parity_err / rx_frame_err (result).
// Options     : UART_PARITY_EN -- when defined, a parity bit is expected
//               after the data bits and is checked.
// Revision    : 1.0 -- initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler
    import UartGlobalPkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

    localparam int                   CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic                 PAR_INIT  = (PARITY_ODD != 0);
    localparam logic                 PAR_EN    = (PARITY_BITS != 0);

    generate
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
            $error("uart_rx_sampler: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    // The synchronizer and history flops reset to the idle line level, so
    // leaving reset never looks like a start edge.
    logic sync1_q, sync2_q, hist_q;
    logic w_fall;

    uart_state_e                state_q, state_d;
    logic [CNT_W-1:0]           clk_cnt_q, clk_cnt_d;
    logic [BIT_CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]      shift_q, shift_d;
    logic                       par_acc_q, par_acc_d;
    logic                       ferr_acc_q, ferr_acc_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic                       w_bit_end;

    // A falling edge needs a 1 followed by a 0. A line held low therefore
    // cannot re-arm the receiver until it has gone high again.
    assign w_fall    = hist_q & ~sync2_q;
    assign w_bit_end = (clk_cnt_q == BIT_END);

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;

        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (w_fall) begin
                    state_d    = ST_START;
                    bit_cnt_d  = '0;
                    ferr_acc_d = 1'b0;
                    // Seeding with the parity sense makes the accumulator
                    // end at 0 for a correct frame, in both odd and even modes.
                    par_acc_d  = PAR_INIT;
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF_END) begin
                    clk_cnt_d = '0;
                    state_d   = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = {sync2_q, shift_q[DATA_WIDTH-1:1]};
                    par_acc_d = par_acc_q ^ sync2_q;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    clk_cnt_d = '0;
                    par_acc_d = par_acc_q ^ sync2_q;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    clk_cnt_d  = '0;
                    ferr_acc_d = ferr_acc_q | ~sync2_q;
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                        valid_d   = 1'b1;
                        data_d    = shift_q;
                        ferr_d    = ferr_acc_q | ~sync2_q;
                        perr_d    = PAR_EN & par_acc_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            hist_q     <= 1'b1;
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            hist_q     <= sync2_q;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;

endmodule : uart_rx_sampler

`default_nettype wire

// File: rtl/uart_transceiver.sv
// ============================================================================
// Module      : uart_transceiver
// Description : Full-duplex UART engine. The TX FSM serialises words that
//               are accepted on a valid/ready handshake. RX is handled by
//               the uart_rx_sampler sub-module. The two paths are fully
//               independent.
// Ports       : clk, reset (async, active-low)
//               tx_data / tx_valid / tx_ready -- transmit handshake
//               tx -- serial out (idles high), rx -- serial in (async)
//               rx_data / rx_valid / rx_parity_err / rx_frame_err -- result
// Options     : UART_PARITY_EN -- when defined, a parity bit is generated
//               on TX and checked on RX.
// Revision    : 1.0 -- initial release
// ============================================================================
`default_nettype none

module uart_transceiver
    import UartGlobalPkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

    generate
        if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
            $error("uart_transceiver: DATA_WIDTH out of range 5..9");
        end
        if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
            $error("uart_transceiver: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
            $error("uart_transceiver: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    localparam int                   CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic                 PAR_INIT  = (PARITY_ODD != 0);

    uart_state_e           tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_clk_cnt_q, tx_clk_cnt_d;
    logic [BIT_CNT_W-1:0]  tx_bit_cnt_q, tx_bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_q, tx_d;
    logic                  w_tx_bit_end;

    assign w_tx_bit_end = (tx_clk_cnt_q == BIT_END);
    assign tx_ready     = (tx_state_q == ST_IDLE);

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_clk_cnt_d = w_tx_bit_end ? '0 : tx_clk_cnt_q + CNT_W'(1);
        tx_bit_cnt_d = tx_bit_cnt_q;
        tx_shift_d   = tx_shift_q;
        tx_par_d     = tx_par_q;

        case (tx_state_q)
            ST_IDLE: begin
                tx_clk_cnt_d = '0;
                if (tx_valid) begin
                    tx_state_d   = ST_START;
                    tx_bit_cnt_d = '0;
                    tx_shift_d   = tx_data;
                    tx_par_d     = (^tx_data) ^ PAR_INIT;
                end
            end
            ST_START: begin
                if (w_tx_bit_end) begin
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tx_bit_end) begin
                    tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
                    if (tx_bit_cnt_q == DATA_LAST) begin
                        tx_bit_cnt_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d   = ST_PARITY;
`else
                        tx_state_d   = ST_STOP;
`endif
                    end else begin
                        tx_bit_cnt_d = tx_bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_tx_bit_end) begin
                    tx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tx_bit_end) begin
                    if (tx_bit_cnt_q == STOP_LAST) begin
                        tx_bit_cnt_d = '0;
                        tx_state_d   = ST_IDLE;
                    end else begin
                        tx_bit_cnt_d = tx_bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                tx_state_d   = ST_IDLE;
                tx_clk_cnt_d = '0;
            end
        endcase

        // The line level is decoded from the next state and then registered,
        // so the pin is driven glitch-free straight from a flop.
        case (tx_state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_shift_d[0];
            ST_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= ST_IDLE;
            tx_clk_cnt_q <= '0;
            tx_bit_cnt_q <= '0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_clk_cnt_q <= tx_clk_cnt_d;
            tx_bit_cnt_q <= tx_bit_cnt_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            tx_q         <= tx_d;
        end
    end

    assign tx = tx_q;

    uart_rx_sampler #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS),
        .PARITY_ODD   (PARITY_ODD)
    ) u_rx_sampler (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err)
    );

endmodule : uart_transceiver

`default_nettype wire

// File: doc/uart_transceiver.md
# uart_transceiver

Parametrised full-duplex UART engine driving and sampling the `tx`/`rx` pins of the UART interface. It serialises parallel words onto `tx` through a valid/ready handshake and deserialises `rx` into words with error flags. Data width, bit period, stop-bit count and parity sense are all configurable. It is the synthesizable DUT that the UART AVIP agents drive and monitor.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, `clk` cycles per bit period; must be ≥4.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored unless parity is compiled in.
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_WIDTH  word to transmit.
- tx_valid  input  1  `tx_data` valid.
- tx_ready  output  1  transmitter can accept a word.
- tx  output  1  serial output; idles high.
- rx  input  1  serial input; asynchronous to `clk`.
- rx_data  output  DATA_WIDTH  last received word; holds until the next frame completes.
- rx_valid  output  1  one-cycle pulse when a frame completes.
- rx_parity_err  output  1  parity mismatch; valid only with `rx_valid`.
- rx_frame_err  output  1  stop bit sampled low; valid only with `rx_valid`.

## Operation
- Frame format: start bit (0), then DATA_WIDTH bits LSB first, then parity (if compiled in), then STOP_BITS stop bits (1). Let P = 1 if parity is compiled in, else 0.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - `tx_ready` = 1 only in IDLE.
  - A transfer occurs when `tx_valid` and `tx_ready` are both high. It captures `tx_data` and moves to START.
  - Each state holds `tx` for exactly CLKS_PER_BIT cycles per bit.
  - A bit counter tracks DATA and STOP bits.
  - DATA → PARITY when P = 1, otherwise DATA → STOP.
  - STOP → IDLE after STOP_BITS periods.
- RX front end: a 2-flop synchronizer on `rx`, plus one history flop for falling-edge detection.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a synchronized falling edge.
  - START waits CLKS_PER_BIT/2 cycles and then samples. If the sample is 1 it is a false start and the FSM returns to IDLE with no output.
  - All following bits are sampled every CLKS_PER_BIT cycles, i.e. at mid-bit.
  - DATA shifts bits in LSB first.
  - Every stop bit is sampled. Any stop sample of 0 sets the frame error.
  - After the last stop sample, the FSM returns to IDLE and flags the frame complete.
- Frame-complete outputs: `rx_data` updates, `rx_valid` pulses for one cycle, and both error flags are registered together with it. Errors never suppress `rx_valid`.
- Parity is computed as the XOR of the data bits, XOR PARITY_ODD.
- TX and RX are fully independent. Simultaneous activity on both is legal.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `rx_parity_err`=0, `rx_frame_err`=0. All FSMs go to IDLE and all counters to 0.
- TX latency:
  - `tx` goes low on the cycle after the transfer.
  - `tx_ready` deasserts on that same cycle.
  - `tx_ready` reasserts exactly (1+DATA_WIDTH+P+STOP_BITS)×CLKS_PER_BIT cycles after the transfer.
- Back-to-back TX: if `tx_valid` is held high, the next start bit begins on the cycle after `tx_ready` reasserts. No extra idle bit is inserted.
- `tx_data` is ignored while `tx_ready` = 0.
- RX latency: `rx_valid` rises 1 cycle after the final stop-bit sample. That sample occurs 2 synchronizer cycles plus CLKS_PER_BIT/2 cycles into the last stop bit.
- Line held low after a frame error: RX waits for `rx` to return high before re-arming edge detection. A stuck-low line must not produce repeated frames.
- Reset asserted mid-frame takes effect immediately:
  - `tx` returns to 1 and the partial frame is abandoned.
  - The partial RX word is discarded with no `rx_valid`.

## Configuration
- Macro: `UART_PARITY_EN`.
- Defined: P = 1. The parity bit is generated on TX and checked on RX. `rx_parity_err` reports a mismatch.
- Undefined: P = 0. No parity bit appears in either direction. `rx_parity_err` is tied to 0 and PARITY_ODD has no effect.

## Structure
- The shared UartGlobalPkg holds:
  - The FSM state typedef (IDLE, START, DATA, PARITY, STOP), shared by TX and RX.
  - The legal ranges of DATA_WIDTH and STOP_BITS, checked by elaboration-time assertions.
- One sub-module: `uart_rx_sampler`. It contains the synchronizer, edge detect, RX FSM and RX output registers.
- The TX FSM lives in `uart_transceiver`.

## Test plan
Bench configuration: DATA_WIDTH=8, CLKS_PER_BIT=16, STOP_BITS=1.
- Reset check: assert `reset` low → `tx`=1, `tx_ready`=1, `rx_valid`=0; all hold for 100 cycles after release with no input activity.
- TX 0xA5 without `UART_PARITY_EN`:
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, with each bit 16 cycles.
  - `tx_ready` returns high 160 cycles after the transfer.
- TX 0xA5 with `UART_PARITY_EN` and PARITY_ODD=0:
  - Parity bit = 0.
  - `tx_ready` returns after 176 cycles.
  - Back-to-back second word 0x3C starts on the next cycle.
- Loopback of `tx` to `rx` sending 0x3C, 0x00, 0xFF → exactly three `rx_valid` pulses carrying those values, with both error flags at 0.
- `rx` glitched low for 4 cycles → no `rx_valid`; the RX FSM returns to IDLE.
- Frame with stop bit forced to 0 → `rx_valid` pulses with `rx_frame_err`=1.
  - Also, with parity compiled in, a flipped parity bit → `rx_parity_err`=1.
  - Also, `reset` asserted during the TX DATA state → `tx`=1 immediately and `tx_ready`=1.
